// File: rtl/subtrator_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package subtrator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res++;
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/subtrator_serial_if.sv
// Operand/result bundle for subtrator_serial; master issues requests, slave computes.
interface subtrator_serial_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, bin,
        input  d, bout, ovf, busy, done
    );

    modport slave (
        input  start, a, b, bin,
        output d, bout, ovf, busy, done
    );
endinterface

// File: rtl/subtrator_serial_completo.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout is the borrow out.
module subtratorCompleto (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial subtractor: one full-subtractor cell, LSB first, WIDTH cycles per result.
// Optional signed overflow flag enabled by SUBTRATOR_SERIAL_OVF_EN.
module subtrator_serial
    import subtrator_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    subtrator_serial_if.slave bus
);
    localparam int unsigned     CW       = clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, rb_q;
    logic [WIDTH-2:0] res_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q, bout_q;
    logic             load, shift, finish;
    logic             di, bo;
    logic [WIDTH-1:0] res_next;

    subtratorCompleto u_cell (
        .a    (ra_q[0]),
        .b    (rb_q[0]),
        .bin  (br_q),
        .d    (di),
        .bout (bo)
    );

    // Full result once the current bit is shifted in; only the top WIDTH-1 bits are kept.
    assign res_next = {di, res_q};

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                ra_q  <= bus.a;
                rb_q  <= bus.b;
                br_q  <= bus.bin;
                cnt_q <= '0;
            end else if (shift) begin
                ra_q  <= ra_q >> 1;
                rb_q  <= rb_q >> 1;
                br_q  <= bo;
                cnt_q <= cnt_q + CW'(1);
                res_q <= res_next[WIDTH-1:1];
            end
            if (finish) begin
                d_q    <= res_next;
                bout_q <= bo;
            end
        end
    end

`ifdef SUBTRATOR_SERIAL_OVF_EN
    logic sb_q, ovf_q;

    // On the last bit ra_q[0] is the original sign of a and di is the result sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            if (load) begin
                sb_q <= bus.b[WIDTH-1];
            end
            if (finish) begin
                ovf_q <= (ra_q[0] != sb_q) && (di != ra_q[0]);
            end
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.d    = d_q;
    assign bus.bout = bout_q;
    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_subtrator_serial.sv
// Directed self-checking bench for subtrator_serial (WIDTH=4), both ovf build options.
module tb_subtrator_serial;
    localparam int unsigned WIDTH = 4;
`ifdef SUBTRATOR_SERIAL_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [WIDTH-1:0] prev_d;

    always #5 clk = ~clk;

    subtrator_serial_if #(.WIDTH(WIDTH)) bus ();

    subtrator_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start; operands are scrambled after the accept edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic bin);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        step();
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.bin   = ~bin;
    endtask

    task automatic chk_result(input string tag, input logic [WIDTH-1:0] ed, input logic eb,
                              input logic eo);
        chk({tag, ".done"}, 32'(bus.done), 32'd1);
        chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ".d"},    32'(bus.d),    32'(ed));
        chk({tag, ".bout"}, 32'(bus.bout), 32'(eb));
        chk({tag, ".ovf"},  32'(bus.ovf),  32'(eo & OVF_EN));
    endtask

    // Full single operation: busy window, hidden intermediate, result in cycle WIDTH+1.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bin, input logic [WIDTH-1:0] ed, input logic eb,
                          input logic eo);
        start_op(a, b, bin);
        for (int c = 1; c <= int'(WIDTH); c++) begin
            chk({tag, ".busy_win"}, 32'(bus.busy), 32'd1);
            chk({tag, ".nodone"},   32'(bus.done), 32'd0);
            chk({tag, ".dhold"},    32'(bus.d),    32'(prev_d));
            step();
        end
        chk_result(tag, ed, eb, eo);
        prev_d = ed;
        step();
        chk({tag, ".pulse"}, 32'(bus.done), 32'd0);
        chk({tag, ".idle"},  32'(bus.busy), 32'd0);
    endtask

    initial begin
        int pulses;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        prev_d    = '0;

        #12;
        chk("rst.d",    32'(bus.d),    32'd0);
        chk("rst.bout", 32'(bus.bout), 32'd0);
        chk("rst.ovf",  32'(bus.ovf),  32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        step();

        // 9-5: unsigned 4, signed -7-5 overflows.
        run_op("op_9_5",  4'd9, 4'd5, 1'b0, 4'd4,  1'b0, 1'b1);
        run_op("op_3_5",  4'd3, 4'd5, 1'b0, 4'd14, 1'b1, 1'b0);
        run_op("op_0_0b", 4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0);
        run_op("op_8_1",  4'd8, 4'd1, 1'b0, 4'd7,  1'b0, 1'b1);

        // start pulsed during SHIFT must be ignored: 10-3-1 = 6.
        start_op(4'd10, 4'd3, 1'b1);
        step();
        bus.start = 1'b1;
        bus.a     = 4'd15;
        bus.b     = 4'd15;
        bus.bin   = 1'b0;
        step();
        step();
        bus.start = 1'b0;
        step();
        chk_result("ign", 4'd6, 1'b0, 1'b1);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.done === 1'b1) pulses++;
        end
        chk("ign.pulses", 32'(pulses),   32'd0);
        chk("ign.idle",   32'(bus.busy), 32'd0);

        // Back-to-back with start held: 6-2 then 2-6.
        bus.start = 1'b1;
        bus.a     = 4'd6;
        bus.b     = 4'd2;
        bus.bin   = 1'b0;
        step();
        bus.a = 4'd2;
        bus.b = 4'd6;
        for (int c = 1; c < 5; c++) step();
        chk_result("b2b1", 4'd4, 1'b0, 1'b0);
        step();
        bus.start = 1'b0;
        chk("b2b.busy6", 32'(bus.busy), 32'd1);
        for (int c = 6; c < 10; c++) begin
            chk("b2b.nodone", 32'(bus.done), 32'd0);
            step();
        end
        chk_result("b2b2", 4'd12, 1'b1, 1'b0);
        step();
        chk("b2b.end", 32'(bus.done), 32'd0);

        // Reset in cycle 3 aborts at once and leaves no done pulse.
        start_op(4'd7, 4'd2, 1'b0);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.d",    32'(bus.d),    32'd0);
        chk("abort.bout", 32'(bus.bout), 32'd0);
        chk("abort.ovf",  32'(bus.ovf),  32'd0);
        chk("abort.busy", 32'(bus.busy), 32'd0);
        chk("abort.done", 32'(bus.done), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        chk("abort.quiet", 32'(pulses), 32'd0);
        prev_d = '0;
        run_op("after_rst", 4'd5, 4'd3, 1'b0, 4'd2, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
